// File: rtl/world_pkg.sv
// Shared tile-map types: tile encoding, FSM states, default map size and thresholds.
// Map dimensions are also used by the renderer.
package world_pkg;

  typedef enum logic [1:0] {
    TILE_WATER = 2'd0,
    TILE_GRASS = 2'd1,
    TILE_TREE  = 2'd2,
    TILE_ROCK  = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } gen_state_t;

  localparam int unsigned MAP_W_DEF    = 32;
  localparam int unsigned MAP_H_DEF    = 24;
  localparam int unsigned MAP_ADDR_W   = 10;
  localparam int unsigned WATER_TH_DEF = 64;
  localparam int unsigned GRASS_TH_DEF = 192;
  localparam int unsigned TREE_TH_DEF  = 240;
  localparam int          SPAWN_X_DEF  = 16;
  localparam int          SPAWN_Y_DEF  = 12;

endpackage

// File: rtl/world_tile_gen_if.sv
// Generator control and tile-map write port; master = generator, slave = RNG/arbiter side.
// Writes use valid/ready; wr_valid_out never depends on wr_ready_in.
interface world_tile_gen_if
  import world_pkg::*;
#(
  parameter int unsigned ADDR_W = MAP_ADDR_W
);
  logic              start_in;
  logic [15:0]       rnd_in;
  logic              wr_ready_in;
  logic              wr_valid_out;
  logic [ADDR_W-1:0] wr_addr_out;
  tile_t             wr_data_out;
  logic              busy_out;
  logic              done_out;

  modport master (
    input  start_in, rnd_in, wr_ready_in,
    output wr_valid_out, wr_addr_out, wr_data_out, busy_out, done_out
  );

  modport slave (
    output start_in, rnd_in, wr_ready_in,
    input  wr_valid_out, wr_addr_out, wr_data_out, busy_out, done_out
  );
endinterface

// File: rtl/tile_classify.sv
// Combinational byte-to-tile classifier (strict less-than against ascending thresholds).
// Zero latency, no flow control; reused by later biome stages.
module tile_classify
  import world_pkg::*;
#(
  parameter int unsigned WATER_TH = WATER_TH_DEF,
  parameter int unsigned GRASS_TH = GRASS_TH_DEF,
  parameter int unsigned TREE_TH  = TREE_TH_DEF
) (
  input  logic [7:0] rnd_byte,
  output tile_t      tile
);
  // 9-bit compare so a threshold of 256 means "every byte".
  localparam logic [8:0] W_TH = 9'(WATER_TH);
  localparam logic [8:0] G_TH = 9'(GRASS_TH);
  localparam logic [8:0] T_TH = 9'(TREE_TH);

  logic [8:0] val;
  assign val = {1'b0, rnd_byte};

  always_comb begin
    tile = TILE_ROCK;
    if (val < W_TH) begin
      tile = TILE_WATER;
    end else if (val < G_TH) begin
      tile = TILE_GRASS;
    end else if (val < T_TH) begin
      tile = TILE_TREE;
    end
  end
endmodule

// File: rtl/world_tile_gen.sv
// Fills the tile map row-major, one write per cell; MAP_W*MAP_H+1 cycles start-to-done at full rate.
// AXI-style stall holds address/data and skips RNG sampling; WORLD_SPAWN_CLEAR_EN forces GRASS around spawn.
module world_tile_gen
  import world_pkg::*;
#(
  parameter int unsigned MAP_W    = MAP_W_DEF,
  parameter int unsigned MAP_H    = MAP_H_DEF,
  parameter int unsigned ADDR_W   = MAP_ADDR_W,
  parameter int unsigned WATER_TH = WATER_TH_DEF,
  parameter int unsigned GRASS_TH = GRASS_TH_DEF,
  parameter int unsigned TREE_TH  = TREE_TH_DEF,
  parameter int          SPAWN_X  = SPAWN_X_DEF,
  parameter int          SPAWN_Y  = SPAWN_Y_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  world_tile_gen_if.master bus
);
  localparam int X_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int Y_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(MAP_H - 1);

  gen_state_t        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tile_t             tile_q, tile_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  tile_t rnd_tile;
  logic  hs;
  logic  last_cell;
  logic  unused_rnd_hi;

  tile_classify #(
    .WATER_TH (WATER_TH),
    .GRASS_TH (GRASS_TH),
    .TREE_TH  (TREE_TH)
  ) u_classify (
    .rnd_byte (bus.rnd_in[7:0]),
    .tile     (rnd_tile)
  );

  assign unused_rnd_hi = ^bus.rnd_in[15:8];
  assign hs            = valid_q & bus.wr_ready_in;
  assign last_cell     = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    tile_d  = tile_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          state_d = ST_FILL;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          tile_d  = rnd_tile;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_FILL: begin
        if (hs) begin
          if (last_cell) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // The next cell's tile is sampled only when the current one is accepted.
            tile_d = rnd_tile;
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      tile_q  <= TILE_WATER;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      tile_q  <= tile_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef WORLD_SPAWN_CLEAR_EN
  int   x_i, y_i;
  logic in_spawn;

  assign x_i = int'(x_q);
  assign y_i = int'(y_q);
  // Window clips at the edges naturally since x/y never leave the map.
  assign in_spawn = (x_i >= SPAWN_X - 1) && (x_i <= SPAWN_X + 1) &&
                    (y_i >= SPAWN_Y - 1) && (y_i <= SPAWN_Y + 1);
  assign bus.wr_data_out = (valid_q && in_spawn) ? TILE_GRASS : tile_q;
`else
  localparam int unused_spawn = SPAWN_X + SPAWN_Y;
  assign bus.wr_data_out = tile_q;
`endif

  assign bus.wr_valid_out = valid_q;
  assign bus.wr_addr_out  = addr_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;
endmodule

// File: tb/tb_world_tile_gen.sv
// Bench for world_tile_gen: threshold table, full-rate, stalled, restart-ignored, reset-abort runs;
// spawn-clear image check when WORLD_SPAWN_CLEAR_EN is defined.
module tb_world_tile_gen;
  localparam int MW = 32;
  localparam int MH = 24;
  localparam int NC = MW * MH;

  typedef struct {
    logic [15:0] rnd;
    logic [1:0]  exp_tile;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  world_tile_gen_if #(.ADDR_W(10)) bus ();

  world_tile_gen dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard / monitor state
  int   sb[$];
  logic [1:0] mem [NC];
  int   exp_addr = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   m_cyc = 0;
  int   m_lat = 0;
  bit   m_busy = 0;
  bit   stall_pend = 0;
  logic [9:0] stall_addr;
  logic [1:0] stall_data;
  int   e_tile;

  vec_t tbl[8];
  bit   rdy_pat[4];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out / no data", name);
  endtask

  function automatic int classify(input logic [7:0] b);
    if (b < 8'd64)  return 0;
    if (b < 8'd192) return 1;
    if (b < 8'd240) return 2;
    return 3;
  endfunction

  function automatic bit spawn_cell(input int a);
`ifdef WORLD_SPAWN_CLEAR_EN
    return (a / MW >= 11) && (a / MW <= 13) && (a % MW >= 15) && (a % MW <= 17);
`else
    return (a < 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_busy = 0;
      stall_pend = 0;
    end else begin
      if (m_busy) m_cyc++;
      if (bus.start_in && !m_busy) begin
        m_busy = 1;
        m_cyc = 0;
        exp_addr = 0;
        hs_cnt = 0;
        done_cnt = 0;
        sb.push_back(classify(bus.rnd_in[7:0]));
      end
      if (bus.wr_valid_out) begin
        if (stall_pend) begin
          check("stall_addr_hold", 32'(bus.wr_addr_out), int'(stall_addr));
          check("stall_data_hold", 32'(bus.wr_data_out), int'(stall_data));
          stall_pend = 0;
        end
        if (bus.wr_ready_in) begin
          check("wr_addr", 32'(bus.wr_addr_out), exp_addr);
          if (sb.size() == 0) begin
            fail("scoreboard_empty");
          end else begin
            e_tile = sb.pop_front();
            if (spawn_cell(exp_addr)) e_tile = 1;
            check("wr_data", 32'(bus.wr_data_out), e_tile);
          end
          if (exp_addr < NC) mem[exp_addr] = bus.wr_data_out;
          hs_cnt++;
          if (exp_addr != NC - 1) sb.push_back(classify(bus.rnd_in[7:0]));
          exp_addr++;
        end else begin
          stall_pend = 1;
          stall_addr = bus.wr_addr_out;
          stall_data = bus.wr_data_out;
        end
      end
      if (bus.done_out) begin
        done_cnt++;
        m_lat = m_cyc;
        m_busy = 0;
      end
    end
  end

  task automatic start_run(input logic [15:0] r);
    bus.rnd_in   = r;
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == 0) fail(name);
    @(posedge clk); #1;
  endtask

  task automatic check_after_run(input string tag);
    check({tag, "_writes"}, 32'(hs_cnt), NC);
    check({tag, "_done_pulses"}, 32'(done_cnt), 1);
    check({tag, "_busy_after"}, 32'(bus.busy_out), 0);
    check({tag, "_done_after"}, 32'(bus.done_out), 0);
    check({tag, "_valid_after"}, 32'(bus.wr_valid_out), 0);
  endtask

  initial begin
    tbl[0] = '{16'h003F, 2'd0};
    tbl[1] = '{16'hFF40, 2'd1};
    tbl[2] = '{16'h12BF, 2'd1};
    tbl[3] = '{16'h00C0, 2'd2};
    tbl[4] = '{16'h80EF, 2'd2};
    tbl[5] = '{16'h00F0, 2'd3};
    tbl[6] = '{16'h7FFF, 2'd3};
    tbl[7] = '{16'hAB00, 2'd0};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    bus.start_in    = 1'b0;
    bus.rnd_in      = 16'h0000;
    bus.wr_ready_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.wr_valid_out), 0);
    check("rst_addr", 32'(bus.wr_addr_out), 0);
    check("rst_data", 32'(bus.wr_data_out), 0);
    check("rst_busy", 32'(bus.busy_out), 0);
    check("rst_done", 32'(bus.done_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run A: constant water byte, full rate
    bus.wr_ready_in = 1'b1;
    start_run(16'h0030);
    check("a_busy_first", 32'(bus.busy_out), 1);
    check("a_valid_first", 32'(bus.wr_valid_out), 1);
    wait_done(2000, "a_done_timeout");
    check("a_latency", 32'(m_lat), NC + 1);
    check_after_run("a");

    // Run B: threshold table on the first eight writes, random afterwards
    start_run(tbl[0].rnd);
    bus.rnd_in = tbl[1].rnd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tbl_data", 32'(bus.wr_data_out), int'(tbl[i].exp_tile));
      check("tbl_addr", 32'(bus.wr_addr_out), i);
      @(posedge clk); #1;
      bus.rnd_in = (i + 2 < 8) ? tbl[i + 2].rnd : 16'($urandom);
    end
    wait_done(2000, "b_done_timeout");
    check("b_latency", 32'(m_lat), NC + 1);
    check_after_run("b");

    // Run C: ready 1,0,0,1 with fresh rnd every cycle; restart pulse at write 100
    begin
      bit restarted = 0;
      start_run(16'($urandom));
      for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
        bus.wr_ready_in = rdy_pat[c % 4];
        bus.rnd_in      = 16'($urandom);
        bus.start_in    = 1'b0;
        if (hs_cnt >= 100 && !restarted) begin
          bus.start_in = 1'b1;
          restarted = 1;
        end
        @(posedge clk); #1;
      end
      bus.start_in    = 1'b0;
      bus.wr_ready_in = 1'b1;
      if (done_cnt == 0) fail("c_done_timeout");
      repeat (4) @(posedge clk);
      #1;
      check_after_run("c");
    end

    // Run D: reset at write 300, then restart from address 0
    start_run(16'h0080);
    begin
      int c = 0;
      while (hs_cnt < 300 && c < 1000) begin
        @(negedge clk);
        c++;
      end
      if (hs_cnt < 300) fail("d_reach300_timeout");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("d_rst_valid", 32'(bus.wr_valid_out), 0);
    check("d_rst_addr", 32'(bus.wr_addr_out), 0);
    check("d_rst_data", 32'(bus.wr_data_out), 0);
    check("d_rst_busy", 32'(bus.busy_out), 0);
    repeat (3) @(posedge clk);
    #1;
    check("d_rst_no_done", 32'(done_cnt), 0);
    check("d_rst_done_out", 32'(bus.done_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_run(16'h00C5);
    @(negedge clk);
    check("d_restart_addr", 32'(bus.wr_addr_out), 0);
    check("d_restart_data", 32'(bus.wr_data_out), 2);
    wait_done(2000, "d_done_timeout");
    check_after_run("d");

`ifdef WORLD_SPAWN_CLEAR_EN
    // Run E: all-rock map with cleared spawn window
    start_run(16'h00FF);
    wait_done(2000, "e_done_timeout");
    check_after_run("e");
    for (int a = 0; a < NC; a++) begin
      check("spawn_map", 32'(mem[a]), spawn_cell(a) ? 1 : 3);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
